pulse_shrinker: RTL and testbench

//  Receive end of the pulse-stretch CDC path: takes a stretched, asynchronous level
//  (launched in a foreign clock domain) and restores exactly one single-cycle pulse per

---
 rtl/pulse_shrinker_pkg.sv | 11 +
 rtl/pulse_shrinker_lane.sv | 89 ++++++++
 rtl/pulse_shrinker.sv | 86 ++++++++
 tb/tb_pulse_shrinker.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_shrinker_pkg.sv
// pulse_shrinker_pkg: shared types for the pulse-shrinker receive path.
// Holds the per-lane qualifier state encoding used by pulse_shrinker_lane.
package pulse_shrinker_pkg;

   typedef enum logic [1:0] {
      LS_IDLE,
      LS_QUAL,
      LS_HOLD
   } lane_state_t;

endpackage

// File: rtl/pulse_shrinker_lane.sv
// pulse_shrinker_lane: one lane -- synchroniser, min-high qualifier, one-shot.
// Ports: clk, rst_n, din (async level), fire (strobe), glitch (strobe).
module pulse_shrinker_lane
   import pulse_shrinker_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_HIGH    = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic fire,
   output logic glitch
);

   localparam int HW = $clog2(MIN_HIGH + 1);

   (* async_reg = "true" *)
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   lane_state_t state_q, state_d;
   logic [HW-1:0] hi_cnt_q, hi_cnt_d;
   logic [HW-1:0] hi_inc;
   logic          s;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
   assign s      = sync_q[SYNC_STAGES-1];

   // hi_cnt saturates rather than wrapping
   assign hi_inc = (&hi_cnt_q) ? hi_cnt_q : hi_cnt_q + HW'(1);

   always_comb begin
      state_d  = state_q;
      hi_cnt_d = hi_cnt_q;
      fire     = 1'b0;
      glitch   = 1'b0;
      unique case (state_q)
         LS_IDLE: begin
            if (s) begin
               hi_cnt_d = HW'(1);
               if (MIN_HIGH == 1) begin
                  fire    = 1'b1;
                  state_d = LS_HOLD;
               end else begin
                  state_d = LS_QUAL;
               end
            end
         end
         LS_QUAL: begin
            if (s) begin
               hi_cnt_d = hi_inc;
               if (hi_inc == HW'(MIN_HIGH)) begin
                  fire    = 1'b1;
                  state_d = LS_HOLD;
               end
            end else begin
               // dropped before qualifying: report, no pulse
               glitch   = 1'b1;
               hi_cnt_d = '0;
               state_d  = LS_IDLE;
            end
         end
         LS_HOLD: begin
            if (!s) begin
               hi_cnt_d = '0;
               state_d  = LS_IDLE;
            end
         end
         default: begin
            hi_cnt_d = '0;
            state_d  = LS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         state_q  <= LS_IDLE;
         hi_cnt_q <= '0;
      end else begin
         sync_q   <= sync_d;
         state_q  <= state_d;
         hi_cnt_q <= hi_cnt_d;
      end
   end

endmodule

// File: rtl/pulse_shrinker.sv
// pulse_shrinker: restores one clk-domain pulse per stretched async event.
// Ports: clk, rst_n, signal_in, clr_stats -> pulse_out, pulse_any, pulse_count, glitch_seen.
module pulse_shrinker
   import pulse_shrinker_pkg::*;
#(
   parameter int SIGNAL_WIDTH = 1,
   parameter int SYNC_STAGES  = 2,
   parameter int MIN_HIGH     = 2,
   parameter int CNT_W        = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [SIGNAL_WIDTH-1:0] signal_in,
   input  logic                    clr_stats,
   output logic [SIGNAL_WIDTH-1:0] pulse_out,
   output logic                    pulse_any,
   output logic [CNT_W-1:0]        pulse_count,
   output logic [SIGNAL_WIDTH-1:0] glitch_seen
);

   localparam int PW = $clog2(SIGNAL_WIDTH + 1);
   localparam int SW = CNT_W + PW;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [SIGNAL_WIDTH-1:0] fire, glitch;

   logic [SIGNAL_WIDTH-1:0] pulse_q, pulse_d;
   logic                    any_q, any_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [SIGNAL_WIDTH-1:0] glitch_q, glitch_d;

   logic [PW-1:0]    pop;
   logic [CNT_W-1:0] base;
   logic [SW-1:0]    sum;

   for (genvar i = 0; i < SIGNAL_WIDTH; i++) begin : g_lane
      pulse_shrinker_lane #(
         .SYNC_STAGES (SYNC_STAGES),
         .MIN_HIGH    (MIN_HIGH)
      ) u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .din    (signal_in[i]),
         .fire   (fire[i]),
         .glitch (glitch[i])
      );
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < SIGNAL_WIDTH; i++) begin
         pop = pop + PW'(fire[i]);
      end
   end

   // clear takes effect before this cycle's pulses are added
   always_comb begin
      base     = clr_stats ? '0 : count_q;
      sum      = SW'(base) + SW'(pop);
      count_d  = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
      // a new glitch beats a simultaneous clear
      glitch_d = (clr_stats ? '0 : glitch_q) | glitch;
      pulse_d  = fire;
      any_d    = |fire;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pulse_q  <= '0;
         any_q    <= 1'b0;
         count_q  <= '0;
         glitch_q <= '0;
      end else begin
         pulse_q  <= pulse_d;
         any_q    <= any_d;
         count_q  <= count_d;
         glitch_q <= glitch_d;
      end
   end

   assign pulse_out   = pulse_q;
   assign pulse_any   = any_q;
   assign pulse_count = count_q;
   assign glitch_seen = glitch_q;

endmodule

// File: tb/tb_pulse_shrinker.sv
// tb_pulse_shrinker: scoreboard bench for pulse_shrinker (4 lanes, 4-bit count).
// Reference model works on per-lane run lengths of the delayed input level.
module tb_pulse_shrinker;

   localparam int W  = 4;
   localparam int SS = 2;
   localparam int MH = 2;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  signal_in = '0;
   logic          clr_stats = 1'b0;
   logic [W-1:0]  pulse_out;
   logic          pulse_any;
   logic [CW-1:0] pulse_count;
   logic [W-1:0]  glitch_seen;

   pulse_shrinker #(
      .SIGNAL_WIDTH (W),
      .SYNC_STAGES  (SS),
      .MIN_HIGH     (MH),
      .CNT_W        (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .signal_in   (signal_in),
      .clr_stats   (clr_stats),
      .pulse_out   (pulse_out),
      .pulse_any   (pulse_any),
      .pulse_count (pulse_count),
      .glitch_seen (glitch_seen)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            tag;
      logic [W-1:0]  pulse;
      logic          any;
      logic [CW-1:0] cnt;
      logic [W-1:0]  glitch;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_n = 0;

   always @(posedge clk) edge_n <= edge_n + 1;

   // reference model state
   logic [W-1:0] hist[$];
   int           run[W];
   int           m_cnt = 0;
   logic [W-1:0] m_glitch = '0;

   // one clock of stimulus; expectation is for the edge that follows
   task automatic step(input logic [W-1:0] sig, input logic clr,
                       input logic rst);
      exp_t         e;
      logic [W-1:0] s;
      logic [W-1:0] fire;
      logic [W-1:0] gl;
      @(posedge clk);
      #1;
      signal_in = sig;
      clr_stats = clr;
      fire = '0;
      gl   = '0;
      if (rst) begin
         hist.delete();
         for (int i = 0; i < W; i++) run[i] = 0;
         m_cnt    = 0;
         m_glitch = '0;
      end else begin
         rst_n = 1'b1;
         hist.push_back(sig);
         s = (hist.size() > SS) ? hist[hist.size()-1-SS] : '0;
         if (hist.size() > SS + 1) void'(hist.pop_front());
         for (int i = 0; i < W; i++) begin
            if (s[i]) begin
               if (run[i] < 1000) run[i]++;
               fire[i] = (run[i] == MH);
            end else begin
               gl[i]  = (run[i] > 0) && (run[i] < MH);
               run[i] = 0;
            end
         end
         if (clr) begin
            m_cnt    = 0;
            m_glitch = '0;
         end
         m_cnt = m_cnt + $countones(fire);
         if (m_cnt > (1 << CW) - 1) m_cnt = (1 << CW) - 1;
         m_glitch = m_glitch | gl;
      end
      e.tag    = edge_n + 1;
      e.pulse  = fire;
      e.any    = |fire;
      e.cnt    = m_cnt[CW-1:0];
      e.glitch = m_glitch;
      sb.push_back(e);
      // assert reset only after this cycle's outputs have been sampled
      if (rst) begin
         @(negedge clk);
         #1;
         rst_n = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step('0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string name, input int tag,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s edge %0d: got %0h expected %0h",
                  name, tag, act, exp);
      end
   endtask

   // monitor: compare every expectation whose edge has just occurred
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].tag <= edge_n) begin
            e = sb.pop_front();
            if (e.tag < edge_n) begin
               chk("stale_entry", e.tag, 32'(edge_n), 32'(e.tag));
            end else begin
               chk("pulse_out", e.tag, 32'(pulse_out), 32'(e.pulse));
               chk("pulse_any", e.tag, 32'(pulse_any), 32'(e.any));
               chk("pulse_count", e.tag, 32'(pulse_count), 32'(e.cnt));
               chk("glitch_seen", e.tag, 32'(glitch_seen), 32'(e.glitch));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] cur;
      for (int i = 0; i < W; i++) run[i] = 0;
      repeat (3) step('0, 1'b0, 1'b1);
      idle(4);

      // single event on lane 0
      repeat (5) step(4'b0001, 1'b0, 1'b0);
      idle(8);
      // one-cycle glitch
      step(4'b0001, 1'b0, 1'b0);
      idle(8);
      // long level, short gap, second event
      repeat (100) step(4'b0001, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      repeat (5) step(4'b0001, 1'b0, 1'b0);
      idle(8);
      // lanes 0 and 3 together, clear on the firing cycle
      repeat (3) step(4'b1001, 1'b0, 1'b0);
      step(4'b1001, 1'b1, 1'b0);
      repeat (2) step(4'b1001, 1'b0, 1'b0);
      idle(8);
      // saturation then clear
      repeat (20) begin
         repeat (3) step(4'b0010, 1'b0, 1'b0);
         repeat (2) step(4'b0000, 1'b0, 1'b0);
      end
      step('0, 1'b1, 1'b0);
      idle(4);
      // reset during HOLD with the level still high
      repeat (10) step(4'b0001, 1'b0, 1'b0);
      repeat (2) step(4'b0001, 1'b0, 1'b1);
      repeat (10) step(4'b0001, 1'b0, 1'b0);
      idle(8);

      // randomized traffic
      cur = '0;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < W; i++)
            if ($urandom_range(0, 5) == 0) cur[i] = ~cur[i];
         if ($urandom_range(0, 399) == 0) begin
            repeat ($urandom_range(1, 2)) step(cur, 1'b0, 1'b1);
         end else begin
            step(cur, $urandom_range(0, 39) == 0, 1'b0);
         end
      end
      idle(8);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", edge_n, 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
